// File: rtl/pe_result_drain.sv
// pe_result_drain: snapshots the PE grid results and streams them out over valid/ready with a running checksum
module pe_result_drain #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 16,
  parameter int DATA_W = 32,
  localparam int N = NUM_ROWS * NUM_COLS,
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [N-1:0][DATA_W-1:0]   i_results,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_W-1:0]          o_data,
  output logic [RW-1:0]              o_row,
  output logic [CW-1:0]              o_col,
  output logic                       o_last,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [DATA_W-1:0]          o_checksum
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [N-1:0][DATA_W-1:0] bank;
  logic send, hs, at_last, take;
  assign send = state == SEND;
  assign hs = send & i_ready;
  assign at_last = idx == IW'(N - 1);
  assign take = (state == IDLE) & i_start;
  // state register
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= IDLE;
    else state <= state_nx;
  // next state: start only honoured in IDLE, DONE lasts one cycle
  always_comb
    state_nx = (state == IDLE) ? (i_start ? SEND : IDLE) :
               (state == SEND) ? ((hs && at_last) ? DONE : SEND) : IDLE;
  // snapshot bank; outputs are gated by state so it needs no reset
  always_ff @(posedge i_clk)
    if (take) bank <= i_results;
  // index and checksum advance on each accepted word
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      idx <= '0;
      o_checksum <= '0;
    end else if (take) begin
      idx <= '0;
      o_checksum <= '0;
    end else if (hs) begin
      o_checksum <= o_checksum + o_data;
      if (!at_last) idx <= idx + 1'b1;
    end
  assign o_valid = send;
  assign o_data = send ? bank[idx] : '0;
  assign o_row = send ? RW'(int'(idx) / NUM_COLS) : '0;
  assign o_col = send ? CW'(int'(idx) % NUM_COLS) : '0;
  assign o_last = send & at_last;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
endmodule

// File: tb/tb_pe_result_drain.sv
// tb_pe_result_drain: directed and randomized drains checked against a queue-based reference model
module tb_pe_result_drain;
  localparam int NR = 4;
  localparam int NC = 16;
  localparam int N = NR * NC;
  logic i_clk = 0;
  logic i_reset = 1;
  logic i_start = 0;
  logic i_ready = 0;
  logic [N-1:0][31:0] i_results = '0;
  logic o_valid, o_last, o_busy, o_done;
  logic [31:0] o_data, o_checksum;
  logic [1:0] o_row;
  logic [3:0] o_col;
  int n_checks = 0;
  int n_fail = 0;
  int cyc;
  logic [31:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  pe_result_drain #(.NUM_ROWS(NR), .NUM_COLS(NC), .DATA_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_results(i_results),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_row(o_row), .o_col(o_col),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done), .o_checksum(o_checksum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_last"}, o_last, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_row"}, o_row, 0);
    chk({tag, "_col"}, o_col, 0);
    chk({tag, "_checksum"}, o_checksum, 0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) i_results[i] = 32'(3 * i + 1);
  endtask

  // model snapshot taken from the inputs presented at the start edge
  task automatic start_drain();
    exp_q = {};
    for (int i = 0; i < N; i++) exp_q.push_back(i_results[i]);
    i_start = 1;
    step();
    i_start = 0;
  endtask

  // mode: 0 ready always, 1 ready toggling from 1, 2 random ready
  task automatic drain(input int mode, input int abort_at, input bit iso, input bit late_start, output int cycles);
    int k = 0;
    logic [31:0] sum = 0;
    cycles = 0;
    while (k < N && k != abort_at && cycles < 1000) begin
      chk("valid", o_valid, 1);
      chk("busy", o_busy, 1);
      chk("done_low", o_done, 0);
      chk("data", o_data, exp_q[k]);
      chk("row", o_row, 32'(k / NC));
      chk("col", o_col, 32'(k % NC));
      chk("last", o_last, 32'(k == N - 1));
      chk("checksum_run", o_checksum, sum);
      if (iso && cycles == 1) i_results = {N{32'hFFFF_FFFF}};
      i_start = late_start && cycles == 9;
      if (mode == 0) i_ready = 1;
      else if (mode == 1) i_ready = (cycles % 2) == 0;
      else i_ready = 1'($urandom_range(0, 1));
      if (i_ready) begin
        sum += exp_q[k];
        k++;
      end
      step();
      cycles++;
    end
    i_start = 0;
    if (k != N && k != abort_at) chk("drain_timeout", k, N);
    if (k == N) begin
      chk("done", o_done, 1);
      chk("done_valid", o_valid, 0);
      chk("done_busy", o_busy, 1);
      chk("checksum_final", o_checksum, sum);
    end
  endtask

  initial begin
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge i_clk);
    #1 i_reset = 0;
    step();
    chk("idle_valid", o_valid, 0);
    // basic drain
    fill_ramp();
    start_drain();
    drain(0, -1, 0, 0, cyc);
    chk("basic_cycles", cyc, 64);
    chk("basic_sum", o_checksum, 32'd6112);
    step();
    chk("basic_busy_fall", o_busy, 0);
    chk("basic_done_fall", o_done, 0);
    chk("checksum_hold", o_checksum, 32'd6112);
    // backpressure
    start_drain();
    drain(1, -1, 0, 0, cyc);
    chk("bp_cycles", cyc, 127);
    chk("bp_sum", o_checksum, 32'd6112);
    step();
    // snapshot isolation
    start_drain();
    drain(0, -1, 1, 0, cyc);
    chk("iso_sum", o_checksum, 32'd6112);
    step();
    fill_ramp();
    // ignored starts at T+10 and in the done cycle
    start_drain();
    drain(0, -1, 0, 1, cyc);
    chk("ign_cycles", cyc, 64);
    i_start = 1;
    step();
    i_start = 0;
    chk("ign_busy_fall", o_busy, 0);
    chk("ign_valid", o_valid, 0);
    chk("ign_done", o_done, 0);
    step();
    chk("ign_idle_valid", o_valid, 0);
    chk("ign_idle_busy", o_busy, 0);
    // reset mid-drain after 20 handshakes
    start_drain();
    drain(2, 20, 0, 0, cyc);
    #2 i_reset = 1;
    #1;
    chk_all_zero("abort");
    @(posedge i_clk);
    #1 i_reset = 0;
    i_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_done", o_done, 0);
      chk("abort_no_valid", o_valid, 0);
    end
    start_drain();
    drain(0, -1, 0, 0, cyc);
    chk("restart_sum", o_checksum, 32'd6112);
    step();
    // random data with random backpressure
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) i_results[i] = $urandom;
      start_drain();
      drain(2, -1, 0, 0, cyc);
      step();
    end
    // checksum wrap
    i_results = {N{32'h8000_0000}};
    start_drain();
    drain(0, -1, 0, 0, cyc);
    chk("wrap_sum", o_checksum, 32'd0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Reads the 32-bit accumulator results of the row × column processing-element grid and streams them out one word at a time over a valid/ready interface. On a start pulse it snapshots all results in a single cycle, so the grid keeps running while the drain proceeds. It sits between the grid's per-PE `o_sum` outputs and the top-level result path (`o_val`), and also provides a running 32-bit checksum of the drained words.

## Interface
Parameters:
- `NUM_ROWS`, default 4: grid rows.
- `NUM_COLS`, default 16: grid columns.
- `DATA_W`, default 32: result width.
- Derived: `N = NUM_ROWS*NUM_COLS`; `RW = max(1, $clog2(NUM_ROWS))`; `CW = max(1, $clog2(NUM_COLS))`.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_reset`  in  1  reset; asynchronous, active-high.
- `i_start`  in  1  single-cycle request to snapshot and drain.
- `i_results`  in  [N-1:0][DATA_W-1:0]  grid results; element index = `row*NUM_COLS + col`.
- `o_valid`  out  1  output word valid.
- `i_ready`  in  1  downstream ready.
- `o_data`  out  DATA_W  current result word.
- `o_row`  out  RW  row of the current word.
- `o_col`  out  CW  column of the current word.
- `o_last`  out  1  high with the final word (index N-1).
- `o_busy`  out  1  high whenever the state is not IDLE.
- `o_done`  out  1  one-cycle pulse after the last word is accepted.
- `o_checksum`  out  DATA_W  modulo-2^DATA_W sum of the words accepted since the last start.

## Operation
- The FSM has three states: IDLE, SEND and DONE.
- IDLE:
  - `o_valid` is 0.
  - When `i_start` is 1: copy all of `i_results` into the snapshot bank, set index to 0, clear the checksum, and go to SEND.
- SEND:
  - `o_valid` is 1.
  - `o_data` is the snapshot word at the current index.
  - `o_row` = index / `NUM_COLS`; `o_col` = index % `NUM_COLS`.
  - `o_last` = (index == N-1).
  - A handshake occurs in any cycle where `o_valid & i_ready`. On a handshake, add `o_data` to the checksum (carry out discarded).
  - On a handshake with index < N-1: increment the index.
  - On a handshake with index == N-1: go to DONE.
- DONE: hold for exactly one cycle with `o_done` = 1, then go to IDLE.
- `i_start` is ignored in SEND and DONE. A new drain can only begin from IDLE.
- The snapshot is taken only in IDLE on `i_start`. Changes on `i_results` during SEND or DONE have no effect on the output stream.
- Index wrap: the index never exceeds N-1 and does not wrap back to 0 within a drain.
- `o_checksum` holds its value after DONE until the next accepted start.
- Reset, including mid-drain, forces:
  - state IDLE, index 0, checksum 0;
  - `o_valid`, `o_last`, `o_busy`, `o_done`, `o_data`, `o_row`, `o_col` and `o_checksum` all 0.
- After reset, no `o_done` pulse is produced for the aborted drain.

## Timing
- `i_start` sampled at edge T → `o_valid` = 1 with element 0 from cycle T+1.
- With `i_ready` held at 1:
  - element k is presented in cycle T+1+k;
  - the last element is in cycle T+N;
  - `o_done` is high in cycle T+N+1;
  - the block is back in IDLE in cycle T+N+2, and the earliest accepted restart is the edge at the end of that cycle.
- Stall rule: while `o_valid & ~i_ready`, hold `o_data`, `o_row`, `o_col` and `o_last` stable, and keep `o_valid` at 1. The block never retracts `o_valid`.
- `o_data` may be a mux from the registered index and the snapshot bank. It must not depend combinationally on `i_ready` or `i_results`.
- `o_busy` rises in cycle T+1 and falls in the IDLE cycle after DONE.
- `o_checksum` is final in the `o_done` cycle.

## Test plan
- **Basic drain:** defaults, `i_results[i] = 3*i+1`, `i_ready` = 1, pulse `i_start` → 64 words 1, 4, …, 190 in order. (row, col) goes (0,0)…(3,15). `o_last` is high only on word 190. `o_done` pulses at T+65. `o_checksum` = 6112.
- **Backpressure:** same data, `i_ready` toggling 1,0,1,0… → every word is held stable across its 0 cycles. The sequence and checksum are identical to the basic drain. `o_done` occurs 63 cycles later than in the basic drain.
- **Snapshot isolation:** start the drain, then in cycle T+2 change all `i_results` to 0xFFFF_FFFF → the output is still 1, 4, …, 190, with checksum 6112.
- **Ignored start:** pulse `i_start` in cycle T+10 and in the `o_done` cycle → exactly one drain of 64 words and a single `o_done`. `o_busy` falls at T+66.
- **Reset mid-drain:** assert `i_reset` asynchronously after 20 handshakes → all outputs are 0 immediately and no `o_done` occurs. A fresh start after reset drains from element 0 with checksum 6112.
- **Checksum wrap:** all `i_results` = 0x8000_0000 → checksum = 0 after 64 words. The checksum is 0x8000_0000 after an odd count; check this at word 1.
